// File: rtl/lsqueue_pkg.sv
// -----------------------------------------------------------------------------
// lsqueue_pkg
// Shared definitions for the load/store issue queue: global operand widths,
// the load/store function codes seen on dispatch and issue, the word-index
// boundary used for address disambiguation, and the per-entry source select.
// -----------------------------------------------------------------------------
package lsqueue_pkg;

    // Core-wide tag and data widths; the queue parameters default to these.
    localparam int GLOBAL_TAG_W  = 6;
    localparam int GLOBAL_DATA_W = 32;

    // Function codes carried on dispatch_opcode / issuels_opcode.
    localparam logic ISSUELS_FUNC_LW = 1'b0;
    localparam logic ISSUELS_FUNC_SW = 1'b1;

    // Loads and stores conflict when their addresses match above this bit.
    localparam int WORD_LSB = 2;

    // Where an entry register takes its next contents from.
    typedef enum logic [1:0] {
        ENT_HOLD  = 2'd0,   // keep own contents
        ENT_SHIFT = 2'd1,   // collapse: take entry i+1
        ENT_LOAD  = 2'd2    // take the dispatch port
    } ent_src_e;

endpackage

// File: rtl/lsqueue_entry.sv
// -----------------------------------------------------------------------------
// lsqueue_entry
// One queue slot: the entry register, CDB wake-up for rs and rt, and the
// effective-address adder. Wake-up and the address are applied to whichever
// source is selected, so a shifting or freshly dispatched entry can capture a
// broadcast in the same cycle it moves.
// Ports:
//   clk, reset, flush       clock, synchronous reset, queue flush
//   src_sel                 hold / shift from entry i+1 / load from dispatch
//   cdb_valid/tag/data      result broadcast
//   nxt_*                   contents of entry i+1 (shift source)
//   dsp_*                   dispatch port fields (load source)
//   valid .. addrvalid      current entry contents
// -----------------------------------------------------------------------------
module lsqueue_entry
    import lsqueue_pkg::*;
#(
    parameter int TAG_W  = GLOBAL_TAG_W,
    parameter int DATA_W = GLOBAL_DATA_W,
    parameter int OFF_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  ent_src_e          src_sel,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              nxt_valid,
    input  logic              nxt_opcode,
    input  logic [OFF_W-1:0]  nxt_offset,
    input  logic [TAG_W-1:0]  nxt_rstag,
    input  logic [TAG_W-1:0]  nxt_rttag,
    input  logic [DATA_W-1:0] nxt_rsdata,
    input  logic [DATA_W-1:0] nxt_rtdata,
    input  logic              nxt_rsvalid,
    input  logic              nxt_rtvalid,
    input  logic              dsp_opcode,
    input  logic [OFF_W-1:0]  dsp_offset,
    input  logic [TAG_W-1:0]  dsp_rstag,
    input  logic [TAG_W-1:0]  dsp_rttag,
    input  logic [DATA_W-1:0] dsp_rsdata,
    input  logic [DATA_W-1:0] dsp_rtdata,
    input  logic              dsp_rsvalid,
    input  logic              dsp_rtvalid,
    output logic              valid,
    output logic              opcode,
    output logic [OFF_W-1:0]  offset,
    output logic [TAG_W-1:0]  rstag,
    output logic [TAG_W-1:0]  rttag,
    output logic [DATA_W-1:0] rsdata,
    output logic [DATA_W-1:0] rtdata,
    output logic              rsvalid,
    output logic              rtvalid,
    output logic [DATA_W-1:0] addr,
    output logic              addrvalid
);

    logic              s_valid, s_opcode, s_rsvalid, s_rtvalid;
    logic [OFF_W-1:0]  s_offset;
    logic [TAG_W-1:0]  s_rstag, s_rttag;
    logic [DATA_W-1:0] s_rsdata, s_rtdata;
    logic              n_rsvalid, n_rtvalid;
    logic [DATA_W-1:0] n_rsdata, n_rtdata, n_addr;

    always_comb begin
        s_valid   = valid;
        s_opcode  = opcode;
        s_offset  = offset;
        s_rstag   = rstag;
        s_rttag   = rttag;
        s_rsdata  = rsdata;
        s_rtdata  = rtdata;
        s_rsvalid = rsvalid;
        s_rtvalid = rtvalid;
        case (src_sel)
            ENT_SHIFT: begin
                s_valid   = nxt_valid;
                s_opcode  = nxt_opcode;
                s_offset  = nxt_offset;
                s_rstag   = nxt_rstag;
                s_rttag   = nxt_rttag;
                s_rsdata  = nxt_rsdata;
                s_rtdata  = nxt_rtdata;
                s_rsvalid = nxt_rsvalid;
                s_rtvalid = nxt_rtvalid;
            end
            ENT_LOAD: begin
                s_valid   = 1'b1;
                s_opcode  = dsp_opcode;
                s_offset  = dsp_offset;
                s_rstag   = dsp_rstag;
                s_rttag   = dsp_rttag;
                s_rsdata  = dsp_rsdata;
                s_rtdata  = dsp_rtdata;
                s_rsvalid = dsp_rsvalid;
                s_rtvalid = dsp_rtvalid;
            end
            default: ;
        endcase

        // rs and rt snoop independently; an already-valid operand never changes.
        n_rsvalid = s_rsvalid;
        n_rsdata  = s_rsdata;
        if (cdb_valid && !s_rsvalid && (cdb_tag == s_rstag)) begin
            n_rsvalid = 1'b1;
            n_rsdata  = cdb_data;
        end
        n_rtvalid = s_rtvalid;
        n_rtdata  = s_rtdata;
        if (cdb_valid && !s_rtvalid && (cdb_tag == s_rttag)) begin
            n_rtvalid = 1'b1;
            n_rtdata  = cdb_data;
        end

        // Recomputing every cycle is harmless once rs is valid and means the
        // address is ready in the same edge that captures rs from the CDB.
        n_addr = n_rsdata + {{(DATA_W-OFF_W){s_offset[OFF_W-1]}}, s_offset};
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid     <= 1'b0;
            opcode    <= 1'b0;
            offset    <= '0;
            rstag     <= '0;
            rttag     <= '0;
            rsdata    <= '0;
            rtdata    <= '0;
            rsvalid   <= 1'b0;
            rtvalid   <= 1'b0;
            addr      <= '0;
            addrvalid <= 1'b0;
        end else begin
            valid     <= s_valid;
            opcode    <= s_opcode;
            offset    <= s_offset;
            rstag     <= s_rstag;
            rttag     <= s_rttag;
            rsdata    <= n_rsdata;
            rtdata    <= n_rtdata;
            rsvalid   <= n_rsvalid;
            rtvalid   <= n_rtvalid;
            addr      <= n_addr;
            addrvalid <= n_rsvalid;
        end
    end

endmodule

// File: rtl/lsqueue.sv
// -----------------------------------------------------------------------------
// lsqueue
// Age-ordered load/store issue queue. Entry 0 is the oldest and the queue
// collapses toward 0 on removal. Selection picks the oldest ready entry that
// respects memory ordering: stores only from the head, loads past older
// stores only when those stores have a resolved, different word address.
// Ports:
//   clk, reset, flush              clock, synchronous reset, queue flush
//   dispatch_*                     new instruction and push handshake
//   cdb_tag/data/valid             result broadcast for operand wake-up
//   issuels_*                      selected entry and its accept (done)
//   count                          registered occupancy
// -----------------------------------------------------------------------------
module lsqueue
    import lsqueue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = GLOBAL_TAG_W,
    parameter int DATA_W    = GLOBAL_DATA_W,
    parameter int OFF_W     = 16,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       dispatch_opcode,
    input  logic [OFF_W-1:0]           dispatch_offset,
    input  logic [TAG_W-1:0]           dispatch_rstag,
    input  logic [TAG_W-1:0]           dispatch_rttag,
    input  logic [DATA_W-1:0]          dispatch_rsdata,
    input  logic [DATA_W-1:0]          dispatch_rtdata,
    input  logic                       dispatch_rsvalid,
    input  logic                       dispatch_rtvalid,
    input  logic                       dispatch_en,
    output logic                       dispatch_ready,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    input  logic                       cdb_valid,
    output logic                       issuels_opcode,
    output logic [TAG_W-1:0]           issuels_rttag,
    output logic [DATA_W-1:0]          issuels_addr,
    output logic [DATA_W-1:0]          issuels_data,
    output logic                       issuels_ready,
    input  logic                       issuels_done,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    // One extra, permanently empty slot at index DEPTH feeds the top entry
    // when the queue collapses.
    logic              e_valid     [DEPTH+1];
    logic              e_opcode    [DEPTH+1];
    logic [OFF_W-1:0]  e_offset    [DEPTH+1];
    logic [TAG_W-1:0]  e_rstag     [DEPTH+1];
    logic [TAG_W-1:0]  e_rttag     [DEPTH+1];
    logic [DATA_W-1:0] e_rsdata    [DEPTH+1];
    logic [DATA_W-1:0] e_rtdata    [DEPTH+1];
    logic              e_rsvalid   [DEPTH+1];
    logic              e_rtvalid   [DEPTH+1];
    logic [DATA_W-1:0] e_addr      [DEPTH+1];
    logic              e_addrvalid [DEPTH+1];
    ent_src_e          src_sel     [DEPTH];

    logic [DEPTH-1:0]  cand;
    logic              ent_ready, order_ok;
    logic              sel_found;
    logic [CNT_W-1:0]  sel_idx;
    logic              full, remove, push;
    logic [CNT_W-1:0]  wr_pos;

    assign e_valid[DEPTH]     = 1'b0;
    assign e_opcode[DEPTH]    = 1'b0;
    assign e_offset[DEPTH]    = '0;
    assign e_rstag[DEPTH]     = '0;
    assign e_rttag[DEPTH]     = '0;
    assign e_rsdata[DEPTH]    = '0;
    assign e_rtdata[DEPTH]    = '0;
    assign e_rsvalid[DEPTH]   = 1'b0;
    assign e_rtvalid[DEPTH]   = 1'b0;
    assign e_addr[DEPTH]      = '0;
    assign e_addrvalid[DEPTH] = 1'b0;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        lsqueue_entry #(
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W),
            .OFF_W  (OFF_W)
        ) u_entry (
            .clk         (clk),
            .reset       (reset),
            .flush       (flush),
            .src_sel     (src_sel[i]),
            .cdb_valid   (cdb_valid),
            .cdb_tag     (cdb_tag),
            .cdb_data    (cdb_data),
            .nxt_valid   (e_valid[i+1]),
            .nxt_opcode  (e_opcode[i+1]),
            .nxt_offset  (e_offset[i+1]),
            .nxt_rstag   (e_rstag[i+1]),
            .nxt_rttag   (e_rttag[i+1]),
            .nxt_rsdata  (e_rsdata[i+1]),
            .nxt_rtdata  (e_rtdata[i+1]),
            .nxt_rsvalid (e_rsvalid[i+1]),
            .nxt_rtvalid (e_rtvalid[i+1]),
            .dsp_opcode  (dispatch_opcode),
            .dsp_offset  (dispatch_offset),
            .dsp_rstag   (dispatch_rstag),
            .dsp_rttag   (dispatch_rttag),
            .dsp_rsdata  (dispatch_rsdata),
            .dsp_rtdata  (dispatch_rtdata),
            .dsp_rsvalid (dispatch_rsvalid),
            .dsp_rtvalid (dispatch_rtvalid),
            .valid       (e_valid[i]),
            .opcode      (e_opcode[i]),
            .offset      (e_offset[i]),
            .rstag       (e_rstag[i]),
            .rttag       (e_rttag[i]),
            .rsdata      (e_rsdata[i]),
            .rtdata      (e_rtdata[i]),
            .rsvalid     (e_rsvalid[i]),
            .rtvalid     (e_rtvalid[i]),
            .addr        (e_addr[i]),
            .addrvalid   (e_addrvalid[i])
        );
    end

    // Candidate mask. The head is always eligible when ready; a younger load
    // is blocked by any older store whose address is unknown or hits the same
    // word. Entries are contiguous from 0, so every j<i is a live entry.
    always_comb begin
        cand      = '0;
        ent_ready = 1'b0;
        order_ok  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_ready = e_valid[i] && e_addrvalid[i] &&
                        ((e_opcode[i] == ISSUELS_FUNC_LW) || e_rtvalid[i]);
            order_ok  = (i == 0);
            if ((i != 0) && BYPASS_EN && (e_opcode[i] == ISSUELS_FUNC_LW)) begin
                order_ok = 1'b1;
                for (int j = 0; j < DEPTH; j++) begin
                    if ((j < i) && (e_opcode[j] == ISSUELS_FUNC_SW) &&
                        (!e_addrvalid[j] ||
                         (e_addr[j][DATA_W-1:WORD_LSB] == e_addr[i][DATA_W-1:WORD_LSB]))) begin
                        order_ok = 1'b0;
                    end
                end
            end
            cand[i] = ent_ready && order_ok;
        end
    end

    // Lowest-index candidate wins; with none, index 0 drives the outputs.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_found = 1'b1;
                sel_idx   = CNT_W'(i);
            end
        end
    end

    assign issuels_ready  = sel_found;
    assign issuels_opcode = e_opcode[sel_idx];
    assign issuels_rttag  = e_rttag[sel_idx];
    assign issuels_addr   = e_addr[sel_idx];
    assign issuels_data   = e_rtdata[sel_idx];

    assign full           = (count == CNT_W'(DEPTH));
    assign remove         = issuels_done && sel_found;
    assign dispatch_ready = !full || remove;
    assign push           = dispatch_en && dispatch_ready;
    assign wr_pos         = count - CNT_W'(remove);

    // Entries at and above the removed slot collapse down by one; the push
    // lands at the first free slot after that collapse and overrides a shift.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            src_sel[i] = ENT_HOLD;
            if (remove && (CNT_W'(i) >= sel_idx)) begin
                src_sel[i] = ENT_SHIFT;
            end
            if (push && (CNT_W'(i) == wr_pos)) begin
                src_sel[i] = ENT_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= '0;
        end else if (push && !remove) begin
            count <= count + 1'b1;
        end else if (remove && !push) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_lsqueue.sv
// -----------------------------------------------------------------------------
// tb_lsqueue
// Drives two queues (bypass on / strict FIFO) with the same stimulus. A
// queue-based reference model predicts each cycle's outputs; predictions go
// into scoreboards that a separate monitor drains and compares.
// -----------------------------------------------------------------------------
module tb_lsqueue;
    import lsqueue_pkg::*;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int OFF_W  = 16;
    localparam int CNT_W  = $clog2(DEPTH+1);

    typedef struct packed {
        logic        is_sw;
        logic [15:0] off;
        logic [5:0]  rstag;
        logic [5:0]  rttag;
        logic [31:0] rsdata;
        logic [31:0] rtdata;
        logic        rsv;
        logic        rtv;
    } ment_t;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic        en;
        logic        done;
        logic        cdbv;
        logic [5:0]  cdbtag;
        logic [31:0] cdbdata;
        ment_t       d;
    } stim_t;

    typedef struct packed {
        logic             ready;
        logic             chk_id;
        logic             chk_full;
        logic             op;
        logic [5:0]       rttag;
        logic [31:0]      addr;
        logic [31:0]      data;
        logic             dready;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset, flush;
    logic              dispatch_opcode, dispatch_rsvalid, dispatch_rtvalid, dispatch_en;
    logic [OFF_W-1:0]  dispatch_offset;
    logic [TAG_W-1:0]  dispatch_rstag, dispatch_rttag, cdb_tag;
    logic [DATA_W-1:0] dispatch_rsdata, dispatch_rtdata, cdb_data;
    logic              cdb_valid, issuels_done;

    logic              b_dready, b_op, b_ready;
    logic [TAG_W-1:0]  b_rttag;
    logic [DATA_W-1:0] b_addr, b_data;
    logic [CNT_W-1:0]  b_count;
    logic              f_dready, f_op, f_ready;
    logic [TAG_W-1:0]  f_rttag;
    logic [DATA_W-1:0] f_addr, f_data;
    logic [CNT_W-1:0]  f_count;

    ment_t qb[$];
    ment_t qf[$];
    exp_t  sbb[$];
    exp_t  sbf[$];
    int    vectors     = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    lsqueue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OFF_W(OFF_W), .BYPASS_EN(1'b1)) u_byp (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_opcode(dispatch_opcode), .dispatch_offset(dispatch_offset),
        .dispatch_rstag(dispatch_rstag), .dispatch_rttag(dispatch_rttag),
        .dispatch_rsdata(dispatch_rsdata), .dispatch_rtdata(dispatch_rtdata),
        .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtvalid(dispatch_rtvalid),
        .dispatch_en(dispatch_en), .dispatch_ready(b_dready),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_valid(cdb_valid),
        .issuels_opcode(b_op), .issuels_rttag(b_rttag), .issuels_addr(b_addr),
        .issuels_data(b_data), .issuels_ready(b_ready), .issuels_done(issuels_done),
        .count(b_count)
    );

    lsqueue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OFF_W(OFF_W), .BYPASS_EN(1'b0)) u_fifo (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_opcode(dispatch_opcode), .dispatch_offset(dispatch_offset),
        .dispatch_rstag(dispatch_rstag), .dispatch_rttag(dispatch_rttag),
        .dispatch_rsdata(dispatch_rsdata), .dispatch_rtdata(dispatch_rtdata),
        .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtvalid(dispatch_rtvalid),
        .dispatch_en(dispatch_en), .dispatch_ready(f_dready),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_valid(cdb_valid),
        .issuels_opcode(f_op), .issuels_rttag(f_rttag), .issuels_addr(f_addr),
        .issuels_data(f_data), .issuels_ready(f_ready), .issuels_done(issuels_done),
        .count(f_count)
    );

    function automatic logic [31:0] maddr(input ment_t e);
        return e.rsdata + {{16{e.off[15]}}, e.off};
    endfunction

    // Index of the entry the queue should offer, or -1.
    function automatic int mselect(input ment_t q[$], input bit byp);
        logic [31:0] ai, aj;
        bit          ok;
        for (int i = 0; i < q.size(); i++) begin
            if (!q[i].rsv || (q[i].is_sw && !q[i].rtv)) continue;
            if (i == 0) return 0;
            if (!byp || q[i].is_sw) continue;
            ok = 1'b1;
            ai = maddr(q[i]);
            for (int j = 0; j < i; j++) begin
                aj = maddr(q[j]);
                if (q[j].is_sw && (!q[j].rsv || (aj[31:2] == ai[31:2]))) ok = 1'b0;
            end
            if (ok) return i;
        end
        return -1;
    endfunction

    // Predict this cycle's outputs from the current model, then advance it.
    task automatic modelStep(input bit byp, input stim_t s, output exp_t e);
        ment_t q[$];
        ment_t n;
        int    k;
        if (byp) q = qb; else q = qf;
        k = mselect(q, byp);
        e = '0;
        e.cnt    = CNT_W'(q.size());
        e.ready  = (k >= 0);
        e.dready = (q.size() < DEPTH) || (s.done && (k >= 0));
        if (k >= 0) begin
            e.chk_id   = 1'b1;
            e.chk_full = 1'b1;
            e.op       = q[k].is_sw;
            e.rttag    = q[k].rttag;
            e.addr     = maddr(q[k]);
            e.data     = q[k].rtdata;
        end else if (q.size() > 0) begin
            e.chk_id = 1'b1;
            e.op     = q[0].is_sw;
            e.rttag  = q[0].rttag;
        end
        if (s.rst || s.flush) begin
            q.delete();
        end else begin
            if (s.done && (k >= 0)) q.delete(k);
            if (s.en && e.dready) q.push_back(s.d);
            for (int i = 0; i < q.size(); i++) begin
                n = q[i];
                if (s.cdbv && !n.rsv && (n.rstag == s.cdbtag)) begin
                    n.rsdata = s.cdbdata;
                    n.rsv    = 1'b1;
                end
                if (s.cdbv && !n.rtv && (n.rttag == s.cdbtag)) begin
                    n.rtdata = s.cdbdata;
                    n.rtv    = 1'b1;
                end
                q[i] = n;
            end
        end
        if (byp) qb = q; else qf = q;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e, input logic rdy, input logic op,
                               input logic [5:0] rttag, input logic [31:0] addr,
                               input logic [31:0] data, input logic dr, input logic [CNT_W-1:0] cnt);
        cmp({tag, " issuels_ready"}, 32'(rdy), 32'(e.ready));
        cmp({tag, " dispatch_ready"}, 32'(dr), 32'(e.dready));
        cmp({tag, " count"}, 32'(cnt), 32'(e.cnt));
        if (e.chk_id) begin
            cmp({tag, " opcode"}, 32'(op), 32'(e.op));
            cmp({tag, " rttag"}, 32'(rttag), 32'(e.rttag));
        end
        if (e.chk_full) begin
            cmp({tag, " addr"}, addr, e.addr);
            cmp({tag, " data"}, data, e.data);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        exp_t eb, ef;
        @(negedge clk);
        reset            = s.rst;
        flush            = s.flush;
        dispatch_en      = s.en;
        dispatch_opcode  = s.d.is_sw;
        dispatch_offset  = s.d.off;
        dispatch_rstag   = s.d.rstag;
        dispatch_rttag   = s.d.rttag;
        dispatch_rsdata  = s.d.rsdata;
        dispatch_rtdata  = s.d.rtdata;
        dispatch_rsvalid = s.d.rsv;
        dispatch_rtvalid = s.d.rtv;
        cdb_valid        = s.cdbv;
        cdb_tag          = s.cdbtag;
        cdb_data         = s.cdbdata;
        issuels_done     = s.done;
        modelStep(1'b1, s, eb);
        modelStep(1'b0, s, ef);
        sbb.push_back(eb);
        sbf.push_back(ef);
    endtask

    function automatic stim_t mkIdle(input logic done);
        stim_t s;
        s      = '0;
        s.done = done;
        return s;
    endfunction

    function automatic stim_t mkDisp(input logic sw, input logic [15:0] off,
                                     input logic [5:0] rstag, input logic rsv, input logic [31:0] rsdata,
                                     input logic [5:0] rttag, input logic rtv, input logic [31:0] rtdata);
        stim_t s;
        s          = '0;
        s.en       = 1'b1;
        s.d.is_sw  = sw;
        s.d.off    = off;
        s.d.rstag  = rstag;
        s.d.rsv    = rsv;
        s.d.rsdata = rsdata;
        s.d.rttag  = rttag;
        s.d.rtv    = rtv;
        s.d.rtdata = rtdata;
        return s;
    endfunction

    function automatic stim_t mkCdb(input logic done, input logic [5:0] tag, input logic [31:0] data);
        stim_t s;
        s         = mkIdle(done);
        s.cdbv    = 1'b1;
        s.cdbtag  = tag;
        s.cdbdata = data;
        return s;
    endfunction

    // Monitor: compares the DUT against whatever the driver predicted.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbb.size() > 0) begin
                e = sbb.pop_front();
                checkOutput("byp", e, b_ready, b_op, b_rttag, b_addr, b_data, b_dready, b_count);
            end
            if (sbf.size() > 0) begin
                e = sbf.pop_front();
                checkOutput("fifo", e, f_ready, f_op, f_rttag, f_addr, f_data, f_dready, f_count);
            end
        end
    end

    initial begin
        stim_t s;
        exp_t  er;
        int    o;
        reset = 1'b1; flush = 1'b0; dispatch_en = 1'b0; dispatch_opcode = 1'b0;
        dispatch_offset = '0; dispatch_rstag = '0; dispatch_rttag = '0;
        dispatch_rsdata = '0; dispatch_rtdata = '0; dispatch_rsvalid = 1'b0;
        dispatch_rtvalid = 1'b0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        issuels_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #2;
        er          = '0;
        er.chk_id   = 1'b1;
        er.chk_full = 1'b1;
        er.dready   = 1'b1;
        checkOutput("reset byp", er, b_ready, b_op, b_rttag, b_addr, b_data, b_dready, b_count);
        checkOutput("reset fifo", er, f_ready, f_op, f_rttag, f_addr, f_data, f_dready, f_count);

        // Negative offset wraps the address below the base.
        applyStimulus(mkDisp(1'b0, 16'hFFFC, 6'd1, 1'b1, 32'h100, 6'd2, 1'b1, 32'h0));
        applyStimulus(mkIdle(1'b1));
        applyStimulus(mkIdle(1'b0));

        // Load behind a store with unresolved address, then resolved elsewhere.
        applyStimulus(mkDisp(1'b1, 16'h0, 6'd5, 1'b0, 32'h0, 6'd3, 1'b1, 32'hAA));
        applyStimulus(mkDisp(1'b0, 16'h0, 6'd4, 1'b1, 32'h200, 6'd6, 1'b1, 32'h0));
        applyStimulus(mkIdle(1'b1));
        applyStimulus(mkCdb(1'b0, 6'd5, 32'h300));
        repeat (4) applyStimulus(mkIdle(1'b1));

        // Same-word conflict: the load waits for the store's data and issue.
        applyStimulus(mkDisp(1'b1, 16'h0, 6'd1, 1'b1, 32'h400, 6'd7, 1'b0, 32'h0));
        applyStimulus(mkDisp(1'b0, 16'h0, 6'd2, 1'b1, 32'h402, 6'd3, 1'b1, 32'h0));
        repeat (2) applyStimulus(mkIdle(1'b1));
        applyStimulus(mkCdb(1'b1, 6'd7, 32'h55));
        repeat (3) applyStimulus(mkIdle(1'b1));

        // Fill, refused push while full, then remove and push together.
        for (int i = 0; i < 5; i++)
            applyStimulus(mkDisp(1'b0, 16'h4, 6'd1, 1'b1, 32'h100 * (i + 1), 6'(10 + i), 1'b1, 32'(i)));
        s = mkDisp(1'b0, 16'h8, 6'd1, 1'b1, 32'h800, 6'd20, 1'b1, 32'h0);
        s.done = 1'b1;
        applyStimulus(s);
        repeat (5) applyStimulus(mkIdle(1'b1));

        // Capture from the CDB in the dispatch cycle itself.
        s = mkDisp(1'b0, 16'h0008, 6'd9, 1'b0, 32'h0, 6'd1, 1'b1, 32'h0);
        s.cdbv = 1'b1; s.cdbtag = 6'd9; s.cdbdata = 32'h10;
        applyStimulus(s);
        applyStimulus(mkIdle(1'b1));

        // Flush drops everything including a same-cycle dispatch.
        for (int i = 0; i < 3; i++)
            applyStimulus(mkDisp(1'b1, 16'h0, 6'd1, 1'b0, 32'h0, 6'd2, 1'b0, 32'h0));
        s = mkDisp(1'b0, 16'h0, 6'd1, 1'b1, 32'h40, 6'd2, 1'b1, 32'h0);
        s.flush = 1'b1;
        applyStimulus(s);
        applyStimulus(mkIdle(1'b0));

        for (int n = 0; n < 2000; n++) begin
            s          = '0;
            s.rst      = ($urandom_range(0, 299) == 0);
            s.flush    = ($urandom_range(0, 49) == 0);
            s.en       = ($urandom_range(0, 99) < 60);
            s.done     = 1'($urandom_range(0, 1));
            s.d.is_sw  = 1'($urandom_range(0, 1));
            o          = int'($urandom_range(0, 6)) - 3;
            s.d.off    = 16'(o);
            s.d.rstag  = 6'($urandom_range(0, 7));
            s.d.rsv    = 1'($urandom_range(0, 1));
            s.d.rsdata = 32'h100 * $urandom_range(1, 3) + 32'(4 * $urandom_range(0, 2));
            s.d.rttag  = 6'($urandom_range(0, 7));
            s.d.rtv    = 1'($urandom_range(0, 1));
            s.d.rtdata = $urandom;
            s.cdbv     = 1'($urandom_range(0, 1));
            s.cdbtag   = 6'($urandom_range(0, 7));
            s.cdbdata  = 32'h100 * $urandom_range(1, 3) + 32'(4 * $urandom_range(0, 2));
            applyStimulus(s);
        end

        applyStimulus(mkIdle(1'b0));
        @(negedge clk);
        #4;
        cmp("scoreboard drained", 32'(sbb.size() + sbf.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
